kuz_key_schedule: RTL and testbench
===================================

Name: kuz_key_schedule

Overview:
- Round-key generator for the Kuznyechik (GOST R 34.12-2015) encoder; sits directly upstream of the encryption stage pipeline and supplies the per-stage key that each stage XORs in.
- Accepts a 256-bit master key through a valid/ready handshake.
- Runs the 32-iteration Feistel expansion, one iteration per clock, and stores K1..K10 in a register file.
- Stages read the keys either through a flat bus or through a stage-number-addressed read port.

Parameters:
- NUM_KEYS, 10, number of 128-bit round keys produced (fixed by the standard; not meant to be changed).
- ITERS_PER_PAIR, 8, Feistel iterations between key-pair captures.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous reset, active-high
- key_valid_i  in  1  master key present on key_i
- key_ready_o  out  1  block can accept a new master key
- key_i  in  256  master key; [255:128]=K1, [127:0]=K2
- busy_o  out  1  expansion in progress
- keys_valid_o  out  1  all 10 round keys valid and stable
- round_keys_o  out  1280  flat bus; bits [128*i+127 : 128*i] = K(i+1)
- rd_stage_i  in  4  stage number 0..9 for the read port
- rd_key_o  out  128  registered key for rd_stage_i

Behaviour:
- Reset values (asynchronous rst):
  - state=IDLE, key_ready_o=1, busy_o=0, keys_valid_o=0.
  - All key registers, round_keys_o and rd_key_o = 0.
  - Iteration counter = 0.
- FSM states: IDLE and RUN.
- Handshake: a key is accepted on a rising edge where key_valid_i && key_ready_o.
  - key_ready_o = (state==IDLE), i.e. ~busy_o.
  - key_valid_i is ignored in RUN. The key is not queued; the source must hold it until accepted.
- On acceptance (edge E0):
  - Capture K1, K2 into key[0], key[1].
  - Load Feistel pair (a1,a0) = (K1,K2).
  - cnt=0, state→RUN, busy_o=1, keys_valid_o=0. keys_valid_o drops even if a previous set was valid.
- RUN, each edge: (a1,a0) ← (LSX(a1 ^ C[cnt+1]) ^ a0, a1), then cnt++.
  - LSX = L(S(x)).
  - S applies pi per byte.
  - L is 16 rounds of R; R uses GF(2^8) mod x^8+x^7+x^6+x+1 with coefficients 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1.
- Key capture: on the edge completing iteration cnt ∈ {7,15,23,31}, write the new (a1,a0) into key[2j+2], key[2j+3], with j=cnt/8.
- Completion: the edge completing cnt=31 (E32) sets state→IDLE, busy_o=0, keys_valid_o=1.
  - Latency from acceptance to keys_valid_o = 32 cycles.
  - Next key accepted at the earliest on E33.
- keys_valid_o is sticky until the next acceptance or rst.
- round_keys_o reflects the key registers directly. Intermediate keys are visible while busy; consumers gate on keys_valid_o.
- Read port:
  - rd_key_o ← key[rd_stage_i] on each edge (1-cycle latency), independent of state.
  - rd_stage_i > 9 → rd_key_o ← 0.
- Boundary conditions:
  - rst mid-RUN aborts immediately and clears all state.
  - key_valid_i held high in IDLE after completion restarts expansion on the next edge.

Decomposition:
- Package kuz_pkg holds:
  - PI s-box (256×8).
  - L coefficient array (16×8).
  - GF polynomial 8'hC3 (low byte).
  - C[1..32] iteration constants (128-bit each; C[i] = L(vec(i))).
  - Key/block width localparams (128, 256).
- Sub-module kuz_lsx: combinational 128-bit X/S/L datapath (in: data, const; out: L(S(data^const))). Shared later with encryption stages.

Test Plan:
- RFC 7801 / GOST vector, key_i = 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef → after exactly 32 cycles keys_valid_o=1 with:
  - K3=db31485315694343228d6aef8cc78c44, K4=3d4553d8e9cfec6815ebadc40a9ffd04
  - K5=57646468c44a5e28d3e59246f429f1ac, K6=bd079435165c6432b532e82834da581b
  - K7=51e640757e8745de705727265a0098b1, K8=5a7925017b9fdd3ed72a91a22286f984
  - K9=bb44e25378c73123a5f32f73cdb6e517, K10=72e9dd7416bcf45b755dbaa88e4a4043
- Same key, one cycle after acceptance → K1/K2 already on round_keys_o; first-iteration a1 = LSX(K1^C1), with C1=6ea276726c487ab85d27bd10dd849401.
- key_valid_i pulsed with a different key during RUN → ignored, key_ready_o=0, final keys unchanged from scenario 1.
- rst asserted at cycle 15 of RUN → same cycle busy_o=0, keys_valid_o=0, round_keys_o=0; re-apply key → correct keys 32 cycles later.
- After completion, sweep rd_stage_i 0..15 → rd_key_o one cycle later equals K(n+1) for n ≤ 9, and 0 for n = 10..15.
- Back-to-back: key_valid_i held high with the key changed to all-zero at E32 → accepted at E33, keys_valid_o low E33..E64, high after E65 with K1=K2=0.

Source files
------------

// File: rtl/kuz_pkg.sv
// Shared Kuznyechik constants and helpers: the pi s-box, the L-transform coefficients, and the iteration constants.
// Combinational only, so there is no latency.
// No handshake or backpressure.
package kuz_pkg;

  localparam int BLK_W   = 128;
  localparam int KEY_W   = 256;
  localparam int N_ITERS = 32;

  localparam logic [7:0] GF_POLY = 8'hC3;

  typedef enum logic {ST_IDLE, ST_RUN} ks_state_t;

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // Element 0 multiplies the most significant byte (a15).
  localparam logic [7:0] L_COEF [16] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  // Multiplication in GF(2^8) modulo x^8+x^7+x^6+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    end
    return p;
  endfunction

  // Byte-wise pi substitution.
  function automatic logic [BLK_W-1:0] kuz_s(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int k = 0; k < 16; k++) y[8*k +: 8] = PI[x[8*k +: 8]];
    return y;
  endfunction

  // L is 16 rounds of R. Each R shifts the block down by one byte and places l(a15..a0) in the top byte.
  function automatic logic [BLK_W-1:0] kuz_l(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] v;
    logic [7:0]       acc;
    v = x;
    for (int r = 0; r < 16; r++) begin
      acc = '0;
      for (int k = 0; k < 16; k++) acc = acc ^ gf_mul(L_COEF[15-k], v[8*k +: 8]);
      v = {acc, v[BLK_W-1:8]};
    end
    return v;
  endfunction

  // Iteration constants: entry i holds C[i+1] = L(i+1).
  typedef logic [N_ITERS-1:0][BLK_W-1:0] c_tab_t;

  function automatic c_tab_t gen_c_tab();
    c_tab_t t;
    for (int i = 0; i < N_ITERS; i++) t[i] = kuz_l(BLK_W'(i + 1));
    return t;
  endfunction

  localparam c_tab_t C_TAB = gen_c_tab();

endpackage

// File: rtl/kuz_lsx.sv
// Computes res = L(S(data ^ cst)) for one 128-bit block.
// Purely combinational, so there is no latency.
// No handshake or backpressure.
module kuz_lsx
  import kuz_pkg::*;
(
  input  logic [BLK_W-1:0] data,
  input  logic [BLK_W-1:0] cst,
  output logic [BLK_W-1:0] res
);

  // Key mixing, then substitution, then linear diffusion.
  always_comb begin
    res = kuz_l(kuz_s(data ^ cst));
  end

endmodule

// File: rtl/kuz_key_schedule.sv
// Expands a 256-bit master key into K1..K10 using 32 Feistel iterations, one per clock.
// keys_valid_o rises 32 cycles after the key is accepted. rd_key_o lags rd_stage_i by one cycle.
// key_ready_o is low while an expansion runs. Keys are not queued, so the source must hold key_i until it is accepted.
module kuz_key_schedule
  import kuz_pkg::*;
#(
  parameter int NUM_KEYS       = 10,
  parameter int ITERS_PER_PAIR = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_valid_i,
  output logic                      key_ready_o,
  input  logic [KEY_W-1:0]          key_i,
  output logic                      busy_o,
  output logic                      keys_valid_o,
  output logic [NUM_KEYS*BLK_W-1:0] round_keys_o,
  input  logic [3:0]                rd_stage_i,
  output logic [BLK_W-1:0]          rd_key_o
);

  localparam int TOTAL_ITERS = ITERS_PER_PAIR * (NUM_KEYS - 2) / 2;
  localparam int CNT_W       = $clog2(TOTAL_ITERS);
  localparam int IDX_W       = $clog2(NUM_KEYS);
  localparam logic [3:0] LAST_STAGE = 4'(NUM_KEYS - 1);

  ks_state_t        state;
  logic [BLK_W-1:0] key_q [NUM_KEYS];
  logic [BLK_W-1:0] a1, a0;
  logic [CNT_W-1:0] cnt;
  logic [BLK_W-1:0] lsx_res;
  logic [BLK_W-1:0] nxt_a1;
  logic [IDX_W-1:0] cap_idx;
  logic             pair_done;
  logic             last_iter;

  kuz_lsx u_lsx (
    .data (a1),
    .cst  (C_TAB[cnt]),
    .res  (lsx_res)
  );

  // Next Feistel value, plus the capture slot and end-of-run decode for the current iteration.
  always_comb begin
    nxt_a1    = lsx_res ^ a0;
    pair_done = (int'(cnt) % ITERS_PER_PAIR) == (ITERS_PER_PAIR - 1);
    cap_idx   = IDX_W'(2 * (int'(cnt) / ITERS_PER_PAIR) + 2);
    last_iter = int'(cnt) == (TOTAL_ITERS - 1);
  end

  // Control FSM and key register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      key_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      keys_valid_o <= 1'b0;
      a1           <= '0;
      a0           <= '0;
      cnt          <= '0;
      for (int i = 0; i < NUM_KEYS; i++) key_q[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_valid_i) begin
            key_q[0]     <= key_i[KEY_W-1:BLK_W];
            key_q[1]     <= key_i[BLK_W-1:0];
            a1           <= key_i[KEY_W-1:BLK_W];
            a0           <= key_i[BLK_W-1:0];
            cnt          <= '0;
            state        <= ST_RUN;
            key_ready_o  <= 1'b0;
            busy_o       <= 1'b1;
            keys_valid_o <= 1'b0;
          end
        end
        ST_RUN: begin
          a1  <= nxt_a1;
          a0  <= a1;
          cnt <= cnt + 1'b1;
          if (pair_done) begin
            key_q[cap_idx]        <= nxt_a1;
            key_q[cap_idx + 1'b1] <= a1;
          end
          if (last_iter) begin
            cnt          <= '0;
            state        <= ST_IDLE;
            key_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            keys_valid_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered, stage-addressed read port. Stage numbers outside the key range read back as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_key_o <= '0;
    else     rd_key_o <= (rd_stage_i <= LAST_STAGE) ? key_q[rd_stage_i] : '0;
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_flat
    assign round_keys_o[BLK_W*g +: BLK_W] = key_q[g];
  end

endmodule

// File: tb/tb_kuz_key_schedule.sv
module tb_kuz_key_schedule;
  import kuz_pkg::PI;

  typedef logic [9:0][127:0] ks_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_valid_i;
  logic          key_ready_o;
  logic [255:0]  key_i;
  logic          busy_o;
  logic          keys_valid_o;
  logic [1279:0] round_keys_o;
  logic [3:0]    rd_stage_i;
  logic [127:0]  rd_key_o;

  kuz_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid_i  (key_valid_i),
    .key_ready_o  (key_ready_o),
    .key_i        (key_i),
    .busy_o       (busy_o),
    .keys_valid_o (keys_valid_o),
    .round_keys_o (round_keys_o),
    .rd_stage_i   (rd_stage_i),
    .rd_key_o     (rd_key_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // RFC 7801 round keys K1..K10
  logic [127:0] rfc [10] = '{
    128'h8899aabbccddeeff0011223344556677, 128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44, 128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac, 128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1, 128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517, 128'h72e9dd7416bcf45b755dbaa88e4a4043
  };

  int lc [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};

  // ---------------- reference model ----------------
  function automatic int gm(input int a, input int b);
    int p = 0;
    while (b != 0) begin
      if ((b & 1) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h1C3;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] m_l(input logic [127:0] x);
    int v [16];
    int t;
    logic [127:0] y;
    for (int i = 0; i < 16; i++) v[i] = int'(x[127-8*i -: 8]);
    repeat (16) begin
      t = 0;
      for (int i = 0; i < 16; i++) t = t ^ gm(lc[i], v[i]);
      for (int i = 15; i > 0; i--) v[i] = v[i-1];
      v[0] = t;
    end
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = 8'(v[i]);
    return y;
  endfunction

  function automatic logic [127:0] m_lsx(input logic [127:0] x);
    logic [127:0] s;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = x[8*i +: 8];
      s[8*i +: 8] = PI[b];
    end
    return m_l(s);
  endfunction

  function automatic logic [127:0] m_c(input int i);
    return m_l(128'(i));
  endfunction

  function automatic ks_t m_expand(input logic [255:0] k);
    ks_t ks;
    logic [127:0] x1, x0, t;
    x1 = k[255:128];
    x0 = k[127:0];
    ks[0] = x1;
    ks[1] = x0;
    for (int i = 1; i <= 32; i++) begin
      t  = m_lsx(x1 ^ m_c(i)) ^ x0;
      x0 = x1;
      x1 = t;
      if (i % 8 == 0) begin
        ks[i/4]   = x1;
        ks[i/4+1] = x0;
      end
    end
    return ks;
  endfunction

  // Cycle-level expectation: the full schedule is computed when a key is accepted, and each key pair is revealed when its iteration completes.
  ks_t          m_sched = '0;
  ks_t          m_vis   = '0;
  logic         m_run   = 1'b0;
  logic         m_valid = 1'b0;
  int           m_n     = 0;
  logic [127:0] m_rd    = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0; m_valid = 1'b0; m_n = 0; m_vis = '0; m_rd = '0;
    end else begin
      m_rd = (rd_stage_i < 4'd10) ? m_vis[rd_stage_i] : '0;
      if (!m_run) begin
        if (key_valid_i) begin
          m_sched  = m_expand(key_i);
          m_vis[0] = key_i[255:128];
          m_vis[1] = key_i[127:0];
          m_run = 1'b1; m_valid = 1'b0; m_n = 0;
        end
      end else begin
        m_n++;
        if (m_n % 8 == 0) begin
          m_vis[m_n/4]   = m_sched[m_n/4];
          m_vis[m_n/4+1] = m_sched[m_n/4+1];
        end
        if (m_n == 32) begin
          m_run = 1'b0; m_valid = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("key_ready", 128'(key_ready_o), 128'(!m_run));
    chk("busy", 128'(busy_o), 128'(m_run));
    chk("keys_valid", 128'(keys_valid_o), 128'(m_valid));
    for (int i = 0; i < 10; i++)
      chk($sformatf("round_key[%0d]", i), round_keys_o[128*i +: 128], m_vis[i]);
    chk("rd_key", rd_key_o, m_rd);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    rd_stage_i = 4'($urandom_range(0, 15));
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send_key(input logic [255:0] k);
    int i;
    key_i = k;
    key_valid_i = 1'b1;
    i = 0;
    do begin
      tick();
      i++;
    end while (!busy_o && i < 50);
    chk("accept", 128'(busy_o), 128'd1);
    key_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!keys_valid_o && n < 40) begin
      tick();
      n++;
    end
    chk(name, 128'(n), 128'd32);
  endtask

  logic [255:0] rfc_key;
  ks_t          pin;
  int           n;

  initial begin
    rfc_key = {rfc[0], rfc[1]};
    rst = 1'b1; key_valid_i = 1'b0; key_i = '0; rd_stage_i = '0;
    #2;
    chk("rst_ready", 128'(key_ready_o), 128'd1);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_valid", 128'(keys_valid_o), 128'd0);
    chk("rst_rkeys_nonzero", 128'(|round_keys_o), 128'd0);
    chk("rst_rd_key", rd_key_o, 128'd0);

    // Pin the model to the published values.
    chk("model_C1", m_c(1), 128'h6ea276726c487ab85d27bd10dd849401);
    pin = m_expand(rfc_key);
    for (int i = 2; i < 10; i++) chk($sformatf("model_K%0d", i + 1), pin[i], rfc[i]);

    repeat (2) tick();
    rst = 1'b0;
    tick();

    // RFC vector, with a foreign key pulsed mid-run.
    send_key(rfc_key);
    chk("K1_after_accept", round_keys_o[127:0], rfc[0]);
    chk("K2_after_accept", round_keys_o[255:128], rfc[1]);
    n = 0;
    while (!keys_valid_o && n < 40) begin
      tick();
      n++;
      if (n == 5) begin
        key_i = rand_key();
        key_valid_i = 1'b1;
        chk("ready_low_in_run", 128'(key_ready_o), 128'd0);
      end
      if (n == 7) begin
        key_valid_i = 1'b0;
        key_i = rfc_key;
      end
    end
    chk("rfc_latency", 128'(n), 128'd32);
    for (int i = 0; i < 10; i++) chk($sformatf("rfc_K%0d", i + 1), round_keys_o[128*i +: 128], rfc[i]);

    // Read-port sweep over every stage number.
    for (int s = 0; s < 16; s++) begin
      rd_stage_i = 4'(s);
      @(posedge clk);
      #1;
      chk($sformatf("rd_sweep[%0d]", s), rd_key_o, (s < 10) ? rfc[s] : 128'd0);
    end

    // Random keys with random idle gaps.
    repeat (3) begin
      repeat ($urandom_range(0, 3)) tick();
      send_key(rand_key());
      wait_done("rand_latency");
    end

    // Reset part-way through a run.
    send_key(rfc_key);
    repeat (15) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy_o), 128'd0);
    chk("midrst_valid", 128'(keys_valid_o), 128'd0);
    chk("midrst_rkeys_nonzero", 128'(|round_keys_o), 128'd0);
    tick();
    tick();
    rst = 1'b0;
    send_key(rfc_key);
    wait_done("rerun_latency");
    chk("rerun_K3", round_keys_o[128*2 +: 128], rfc[2]);
    chk("rerun_K10", round_keys_o[128*9 +: 128], rfc[9]);

    // Back-to-back: valid stays high and the key switches to zero when the first run completes.
    key_i = rfc_key;
    key_valid_i = 1'b1;
    tick();
    chk("b2b_accept", 128'(busy_o), 128'd1);
    wait_done("b2b_first_latency");
    key_i = '0;
    tick();
    chk("b2b_valid_low", 128'(keys_valid_o), 128'd0);
    chk("b2b_busy", 128'(busy_o), 128'd1);
    chk("b2b_K1_zero", round_keys_o[127:0], 128'd0);
    chk("b2b_K2_zero", round_keys_o[255:128], 128'd0);
    key_valid_i = 1'b0;
    wait_done("b2b_second_latency");
    chk("b2b_final_valid", 128'(keys_valid_o), 128'd1);
    chk("b2b_final_K1", round_keys_o[127:0], 128'd0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
